mp3_resp_rx: RTL and testbench

// - Serial receiver and frame parser for replies from the MP3 player module; sits beside the command transmitter on the same UART link.
// - Samples the player's TX line, assembles 8N1 bytes and parses 6-byte reply frames: 7E 04 CMD DH DL EF.
// - Presents each valid reply as a one-cycle strobe with command and 16-bit data.
// - Flags malformed or timed-out frames so the track-select logic can re-issue commands.

---
 rtl/mp3_resp_rx_pkg.sv | 24 ++
 rtl/mp3_resp_rx_if.sv | 19 +
 rtl/mp3_resp_rx_uart_rx_byte.sv | 99 +++++++++
 rtl/mp3_resp_rx.sv | 130 +++++++++++++
 tb/tb_mp3_resp_rx.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp3_resp_rx_pkg.sv
// rtl/mp3_resp_rx_pkg.sv - shared MP3 reply frame constants and state encodings
package mp3_resp_rx_pkg;

    localparam logic [7:0] MP3_SOF = 8'h7E;
    localparam logic [7:0] MP3_EOF = 8'hEF;
    localparam logic [7:0] MP3_LEN = 8'h04;

    typedef enum logic [2:0] {
        F_SOF,
        F_LEN,
        F_CMD,
        F_DH,
        F_DL,
        F_EOF
    } frame_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/mp3_resp_rx_if.sv
// rtl/mp3_resp_rx_if.sv - reply strobes and held reply fields from the MP3 reply parser
interface mp3_resp_rx_if;

    logic        resp_valid;
    logic [7:0]  resp_cmd;
    logic [15:0] resp_data;
    logic        track_done;
    logic        frame_err;
    logic        busy;

    modport master (
        output resp_valid, resp_cmd, resp_data, track_done, frame_err, busy
    );

    modport slave (
        input resp_valid, resp_cmd, resp_data, track_done, frame_err, busy
    );

endinterface

// File: rtl/mp3_resp_rx_uart_rx_byte.sv
// rtl/mp3_resp_rx_uart_rx_byte.sv - 2-FF synchroniser and 8N1 byte receiver
module uart_rx_byte
    import mp3_resp_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       rx_active
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          last_q;
    logic          rx_s;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          valid_n, err_n;

    assign rx_s      = sync_q[1];
    assign byte_data = shreg;
    assign rx_active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            last_q     <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx};
            last_q     <= rx_s;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= shreg_n;
            byte_valid <= valid_n;
            byte_err   <= err_n;
        end
    end

    // Counter restarts at every sample point so each sample lands mid-bit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (last_q && !rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == FULL) begin
                    cnt_n   = '0;
                    valid_n = rx_s;
                    err_n   = !rx_s;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/mp3_resp_rx.sv
// rtl/mp3_resp_rx.sv - MP3 player reply receiver: 7E 04 CMD DH DL EF frame parser with timeout
module mp3_resp_rx
    import mp3_resp_rx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 5208,
    parameter int         TIMEOUT_BITS = 20,
    parameter logic [7:0] DONE_CMD     = 8'h3D
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           data_rx,
    mp3_resp_rx_if.master  resp
);

    localparam int TLIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TLIMIT + 1);

    logic [7:0]   byte_data;
    logic         byte_valid, byte_err, rx_active;
    frame_state_t fstate, fstate_n;
    logic [7:0]   shd_cmd, shd_dh, shd_dl, cmd_n, dh_n, dl_n;
    logic [7:0]   out_cmd, out_cmd_n;
    logic [15:0]  out_data, out_data_n;
    logic         valid_q, valid_n, done_q, done_n, err_q, err_n;
    logic [TW-1:0] tcnt;
    logic         timeout;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (data_rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .rx_active  (rx_active)
    );

    assign resp.resp_valid = valid_q;
    assign resp.resp_cmd   = out_cmd;
    assign resp.resp_data  = out_data;
    assign resp.track_done = done_q;
    assign resp.frame_err  = err_q;
    assign resp.busy       = (fstate != F_SOF);

    assign timeout = (fstate != F_SOF) && !rx_active && !byte_valid && (tcnt == TW'(TLIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            fstate   <= F_SOF;
            shd_cmd  <= '0;
            shd_dh   <= '0;
            shd_dl   <= '0;
            out_cmd  <= '0;
            out_data <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tcnt     <= '0;
        end else begin
            fstate   <= fstate_n;
            shd_cmd  <= cmd_n;
            shd_dh   <= dh_n;
            shd_dl   <= dl_n;
            out_cmd  <= out_cmd_n;
            out_data <= out_data_n;
            valid_q  <= valid_n;
            done_q   <= done_n;
            err_q    <= err_n;
            // Saturating idle counter; only meaningful mid-frame.
            if (byte_valid || rx_active || fstate == F_SOF) begin
                tcnt <= '0;
            end else if (tcnt != TW'(TLIMIT)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    always_comb begin
        fstate_n   = fstate;
        cmd_n      = shd_cmd;
        dh_n       = shd_dh;
        dl_n       = shd_dl;
        out_cmd_n  = out_cmd;
        out_data_n = out_data;
        valid_n    = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        if (timeout || (byte_err && fstate != F_SOF)) begin
            err_n    = 1'b1;
            fstate_n = F_SOF;
        end else if (byte_valid) begin
            case (fstate)
                F_SOF: if (byte_data == MP3_SOF) fstate_n = F_LEN;
                F_LEN: begin
                    if (byte_data == MP3_LEN) begin
                        fstate_n = F_CMD;
                    end else begin
                        err_n    = 1'b1;
                        fstate_n = F_SOF;
                    end
                end
                F_CMD: begin
                    cmd_n    = byte_data;
                    fstate_n = F_DH;
                end
                F_DH: begin
                    dh_n     = byte_data;
                    fstate_n = F_DL;
                end
                F_DL: begin
                    dl_n     = byte_data;
                    fstate_n = F_EOF;
                end
                F_EOF: begin
                    fstate_n = F_SOF;
                    if (byte_data == MP3_EOF) begin
                        valid_n    = 1'b1;
                        done_n     = (shd_cmd == DONE_CMD);
                        out_cmd_n  = shd_cmd;
                        out_data_n = {shd_dh, shd_dl};
                    end else begin
                        err_n = 1'b1;
                    end
                end
                default: fstate_n = F_SOF;
            endcase
        end
    end

endmodule

// File: tb/tb_mp3_resp_rx.sv
// tb/tb_mp3_resp_rx.sv - self-checking bench for mp3_resp_rx against a byte-level frame model
`timescale 1ns/1ps
module tb_mp3_resp_rx;

    localparam int CPB = 16;
    localparam int TOB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_rx = 1'b1;

    always #5 clk = ~clk;

    mp3_resp_rx_if rif ();

    mp3_resp_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB),
        .DONE_CMD     (8'h3D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_rx (data_rx),
        .resp    (rif.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // expected strobe list: written by the stimulus process, consumed by the compare process
    logic        ev_err  [1024];
    logic [7:0]  ev_cmd  [1024];
    logic [15:0] ev_data [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic [7:0]  held_cmd  = '0;
    logic [15:0] held_data = '0;
    int n_valid = 0, n_done = 0, n_err = 0;

    // frame model: bytes collected since a 7E was accepted
    int         flen = 0;
    logic [7:0] fbuf [6];

    task automatic push_event(input logic err, input logic [7:0] c, input logic [15:0] d);
        ev_err[wr_ptr]  = err;
        ev_cmd[wr_ptr]  = c;
        ev_data[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            if (flen != 0) push_event(1'b1, 8'h00, 16'h0000);
            flen = 0;
        end else if (flen == 0) begin
            if (b == 8'h7E) begin
                fbuf[0] = b;
                flen = 1;
            end
        end else begin
            fbuf[flen] = b;
            flen++;
            if (flen == 2 && b != 8'h04) begin
                push_event(1'b1, 8'h00, 16'h0000);
                flen = 0;
            end else if (flen == 6) begin
                if (b == 8'hEF) push_event(1'b0, fbuf[2], {fbuf[3], fbuf[4]});
                else            push_event(1'b1, 8'h00, 16'h0000);
                flen = 0;
            end
        end
    endtask

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_ptr    = wr_ptr;
                held_cmd  = '0;
                held_data = '0;
            end else begin
                check("valid_err_overlap", rif.resp_valid & rif.frame_err, 0);
                check("track_done_gated", rif.track_done & ~rif.resp_valid, 0);
                if (rif.resp_valid) begin
                    n_valid++;
                    if (rif.track_done) n_done++;
                    check("valid_was_expected", rd_ptr < wr_ptr, 1);
                    if (rd_ptr < wr_ptr) begin
                        check("event_kind_valid", ev_err[rd_ptr], 0);
                        check("resp_cmd_at_valid", rif.resp_cmd, ev_cmd[rd_ptr]);
                        check("resp_data_at_valid", rif.resp_data, ev_data[rd_ptr]);
                        check("track_done_at_valid", rif.track_done, ev_cmd[rd_ptr] == 8'h3D);
                        held_cmd  = ev_cmd[rd_ptr];
                        held_data = ev_data[rd_ptr];
                        rd_ptr++;
                    end
                end
                if (rif.frame_err) begin
                    n_err++;
                    check("err_was_expected", rd_ptr < wr_ptr, 1);
                    if (rd_ptr < wr_ptr) begin
                        check("event_kind_err", ev_err[rd_ptr], 1);
                        rd_ptr++;
                    end
                end
                check("held_cmd", rif.resp_cmd, held_cmd);
                check("held_data", rif.resp_data, held_data);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(posedge clk);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic stop);
        data_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            data_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        data_rx = stop;
        repeat (CPB) @(posedge clk);
        data_rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok);
        model_byte(b, stop_ok);
        drive_byte(b, stop_ok);
        repeat (2) @(posedge clk);
        #1;
        check("busy_after_byte", rif.busy, flen != 0);
    endtask

    task automatic send_bytes(input logic [47:0] v, input int n);
        for (int k = 0; k < n; k++) send(v[47 - 8 * k -: 8], 1'b1);
    endtask

    task automatic line_timeout();
        if (flen != 0) push_event(1'b1, 8'h00, 16'h0000);
        flen = 0;
        idle_bits(TOB + 1);
        @(posedge clk);
        #1;
        check("busy_after_timeout", rif.busy, 0);
    endtask

    int v0, d0, e0;

    task automatic snap();
        v0 = n_valid;
        d0 = n_done;
        e0 = n_err;
    endtask

    task automatic expect_counts(input string tag, input int dv, input int dd, input int de);
        check({tag, "_valid_count"}, n_valid - v0, dv);
        check({tag, "_done_count"}, n_done - d0, dd);
        check({tag, "_err_count"}, n_err - e0, de);
        check({tag, "_drained"}, rd_ptr, wr_ptr);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_resp_valid"}, rif.resp_valid, 0);
        check({tag, "_resp_cmd"}, rif.resp_cmd, 0);
        check({tag, "_resp_data"}, rif.resp_data, 0);
        check({tag, "_track_done"}, rif.track_done, 0);
        check({tag, "_frame_err"}, rif.frame_err, 0);
        check({tag, "_busy"}, rif.busy, 0);
    endtask

    initial begin
        logic [7:0]  cmd, b;
        logic [15:0] dat;
        logic [47:0] frame;
        int kind, p;

        repeat (5) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        snap();
        send_bytes(48'h7E043D0005EF, 6);
        expect_counts("done_frame", 1, 1, 0);
        check("done_frame_cmd", rif.resp_cmd, 8'h3D);
        check("done_frame_data", rif.resp_data, 16'h0005);

        snap();
        send_bytes(48'h7E04411234EF, 6);
        expect_counts("plain_frame", 1, 0, 0);
        check("plain_frame_cmd", rif.resp_cmd, 8'h41);
        check("plain_frame_data", rif.resp_data, 16'h1234);

        snap();
        send_bytes(48'h7E04410001EE, 6);
        expect_counts("bad_eof", 0, 0, 1);
        check("bad_eof_cmd_held", rif.resp_cmd, 8'h41);
        check("bad_eof_data_held", rif.resp_data, 16'h1234);

        snap();
        send_bytes(48'h7E05410001EF, 6);
        send_bytes(48'h7E043D0001EF, 6);
        expect_counts("bad_len", 1, 1, 1);
        check("bad_len_data", rif.resp_data, 16'h0001);

        snap();
        send_bytes(48'h7E043D000000, 3);
        line_timeout();
        expect_counts("timeout", 0, 0, 1);
        send_bytes(48'h7E0441ABCDEF, 6);
        expect_counts("after_timeout", 1, 0, 1);
        check("after_timeout_data", rif.resp_data, 16'hABCD);

        snap();
        data_rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        data_rx = 1'b1;
        idle_bits(2);
        expect_counts("glitch", 0, 0, 0);
        check("glitch_busy", rif.busy, 0);

        snap();
        send_bytes(48'h7E0400000000, 2);
        send(8'h3D, 1'b0);
        idle_bits(1);
        expect_counts("stop_err", 0, 0, 1);

        snap();
        send_bytes(48'h7E0441120000, 4);
        data_rx = 1'b0;
        repeat (40) @(posedge clk);
        rst = 1'b1;
        data_rx = 1'b1;
        flen = 0;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_byte_reset");
        snap();
        send_bytes(48'h7E043D5678EF, 6);
        expect_counts("after_reset", 1, 1, 0);
        check("after_reset_data", rif.resp_data, 16'h5678);

        for (int it = 0; it < 25; it++) begin
            kind  = $urandom_range(0, 5);
            cmd   = ($urandom_range(0, 1) == 1) ? 8'h3D : 8'($urandom);
            dat   = 16'($urandom);
            p     = $urandom_range(1, 5);
            frame = {8'h7E, 8'h04, cmd, dat, 8'hEF};
            case (kind)
                0: send_bytes(frame, 6);
                1: send_bytes({frame[47:8], 8'($urandom)}, 6);
                2: send_bytes({8'h7E, 8'($urandom), 32'($urandom)}, 4);
                3: begin
                    send_bytes(frame, p);
                    b = 8'($urandom);
                    send(b, 1'b0);
                    idle_bits(1);
                end
                4: begin
                    send_bytes(frame, p);
                    line_timeout();
                end
                default: begin
                    send_bytes(48'($urandom), $urandom_range(1, 3));
                    send_bytes(frame, 6);
                end
            endcase
            idle_bits($urandom_range(0, 2));
        end

        line_timeout();
        idle_bits(2);
        check("final_drained", rd_ptr, wr_ptr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
